// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes for memory
// accesses, the control-FSM state encoding, and a helper that classifies a
// request as illegal (bad funct3 or misaligned).
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RMW   = 3'd2,
        STORE = 3'd3,
        ERR   = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    // True when the request can never complete: unsigned stores do not exist,
    // halves need addr[0]==0 and words need addr[1:0]==0.
    function automatic logic req_is_bad(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = write;
            F3_H:    bad = off[0];
            F3_HU:   bad = write | off[0];
            F3_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering between a 32-bit memory word and the CPU.
// Ports:
//   word_i       memory word (RD)
//   wdata_i      store data from the CPU; low byte/half used for SB/SH
//   off_i        byte offset within the word
//   funct3_i     access size/sign selector
//   load_data_o  selected lane, sign- or zero-extended; 0 for illegal codes
//   store_word_o word_i with the addressed lane replaced by the store data
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    // Shifting the word right by the byte offset puts the addressed lane at
    // bit 0, so byte and half selection share one shifter.
    always_comb begin
        shamt       = {off_i, 3'b000};
        shifted     = word_i >> shamt;
        load_data_o = 32'h0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data_o = {24'h0, shifted[7:0]};
            F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data_o = {16'h0, shifted[15:0]};
            F3_W:    load_data_o = word_i;
            default: load_data_o = 32'h0;
        endcase
    end

    // Store merge: a mask marks the lane being replaced; everything outside
    // it comes from the word read during the RMW cycle.
    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_i;
        case (funct3_i)
            F3_B, F3_BU: begin
                lane_mask = 32'h0000_00FF << shamt;
                lane_data = {24'h0, wdata_i[7:0]} << shamt;
            end
            F3_H, F3_HU: begin
                lane_mask = 32'h0000_FFFF << shamt;
                lane_data = {16'h0, wdata_i[15:0]} << shamt;
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = wdata_i;
            end
        endcase
        store_word_o = (word_i & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-only data memory with combinational reads
// and clocked writes. Sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata  request fields
//   resp_valid                one-cycle completion pulse
//   resp_rdata/resp_err       load result / error flag, held until next accept
//   MemRead/MemWrite/addr/WD  memory strobes, word address and write data
//   RD                        memory read data
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] WD,
    input  logic [DATA_W-1:0] RD
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [2:0]        lat_funct3_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    lsu_lane_align u_align (
        .word_i       (RD),
        .wdata_i      (lat_wdata_q),
        .off_i        (lat_addr_q[1:0]),
        .funct3_i     (lat_funct3_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    // Next-state decode. The request is classified directly from req_* at the
    // accept edge; that only steers the state, never the memory outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_is_bad(req_write, req_funct3, req_addr[1:0]))
                        state_d = ERR;
                    else if (!req_write)
                        state_d = LOAD;
                    else if (req_funct3 == F3_W)
                        state_d = STORE;
                    else
                        state_d = RMW;
                end
            end
            LOAD:    state_d = RESP;
            RMW:     state_d = STORE;
            STORE:   state_d = RESP;
            ERR:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on state and latched fields, so a reset during
    // STORE removes MemWrite before the write edge.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        MemRead    = (state_q == LOAD) || (state_q == RMW);
        MemWrite   = (state_q == STORE);
        addr       = '0;
        WD         = '0;
        if (MemRead || MemWrite)
            addr = {lat_addr_q[ADDR_W-1:2], 2'b00};
        if (MemWrite)
            WD = (lat_funct3_q == F3_W) ? lat_wdata_q : merge_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_addr_q   <= '0;
            lat_funct3_q <= '0;
            lat_wdata_q  <= '0;
            merge_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr_q   <= req_addr;
                        lat_funct3_q <= req_funct3;
                        lat_wdata_q  <= req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                LOAD:    resp_rdata_q <= load_data;
                RMW:     merge_q      <= store_word;
                ERR:     resp_err_q   <= 1'b1;
                default: ;
            endcase
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomised scoreboard bench for lsu_mem_master. A byte-addressed reference
// model predicts each response when the request is accepted; a monitor pops
// predictions as the unit responds and also checks every memory strobe.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] WD;
   logic [31:0] RD;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          nRd;
      int          nWr;
      logic [31:0] waddr;
      logic [31:0] wd;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   exp_t        monEntry;
   logic [31:0] memWords[0:15];
   logic [7:0]  refBytes[0:63];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          rdCnt = 0;
   int          wrCnt = 0;
   int          accs[4];
   int          accTmp;
   logic [7:0]  saved[4];

   lsu_mem_master dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .addr       (addr),
      .WD         (WD),
      .RD         (RD)
   );

   // Clock and a free-running cycle counter used for latency measurement
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Data memory: combinational read, write on the rising edge
   assign RD = MemRead ? memWords[addr[5:2]] : 32'h0;

   always @(posedge clk) begin
      if (MemWrite) memWords[addr[5:2]] = WD;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] refWord(input int base);
      return {refBytes[base + 3], refBytes[base + 2], refBytes[base + 1], refBytes[base]};
   endfunction

   // Reference model: works on individual bytes, decides legality from the
   // access size and address, and updates the byte image on stores.
   task automatic modelRequest(input logic w, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, output exp_t e);
      int     n;
      bit     sgn;
      bit     legal;
      int     base;
      longint v;
      n = 1; sgn = 0; legal = 1;
      case (f3)
         3'd0: begin n = 1; sgn = 1; end
         3'd4: begin n = 1; legal = !w; end
         3'd1: begin n = 2; sgn = 1; end
         3'd5: begin n = 2; legal = !w; end
         3'd2: n = 4;
         default: legal = 0;
      endcase
      base = int'(a[5:0]);
      if (legal && (base % n) != 0) legal = 0;
      e.waddr = {a[31:2], 2'b00};
      e.rdata = 32'h0;
      e.err   = !legal;
      e.nRd   = 0;
      e.nWr   = 0;
      e.wd    = 32'h0;
      e.lat   = 2;
      e.acc   = 0;
      if (legal && !w) begin
         v = 0;
         for (int i = 0; i < n; i++) v = v | (longint'(refBytes[base + i]) << (8 * i));
         if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
         e.rdata = v[31:0];
         e.nRd   = 1;
      end
      if (legal && w) begin
         for (int i = 0; i < n; i++) refBytes[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
         e.wd  = refWord(base & ~3);
         e.nWr = 1;
         if (n < 4) begin
            e.nRd = 1;
            e.lat = 3;
         end
      end
   endtask

   // Drives one request, waits (bounded) for acceptance and records the
   // prediction at the accept cycle.
   task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input bit hold, output int accCyc);
      int   waited;
      exp_t e;
      waited = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         accCyc = -1;
      end else begin
         modelRequest(w, f3, a, wd, e);
         e.acc = cyc;
         sbq.push_back(e);
         accCyc = cyc;
         @(posedge clk);
         #1;
         if (!hold) req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (sbq.size() != 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (sbq.size() != 0) checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
   endtask

   // Monitor: checks memory strobes against the outstanding request and
   // compares each response pulse with the oldest prediction.
   always @(negedge clk) begin
      if (!rst) begin
         if (MemRead || MemWrite) begin
            if (sbq.size() == 0) begin
               checkOutput("strobe_without_request", {30'h0, MemWrite, MemRead}, 32'h0);
            end else begin
               checkOutput("mem_addr", addr, sbq[0].waddr);
               if (MemRead) rdCnt++;
               if (MemWrite) begin
                  wrCnt++;
                  checkOutput("mem_wd", WD, sbq[0].wd);
               end
            end
         end
         if (resp_valid) begin
            if (sbq.size() == 0) begin
               checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
               monEntry = sbq.pop_front();
               checkOutput("resp_rdata", resp_rdata, monEntry.rdata);
               checkOutput("resp_err", {31'h0, resp_err}, {31'h0, monEntry.err});
               checkOutput("latency", 32'(cyc - monEntry.acc), 32'(monEntry.lat));
               checkOutput("read_strobes", 32'(rdCnt), 32'(monEntry.nRd));
               checkOutput("write_strobes", 32'(wrCnt), 32'(monEntry.nWr));
            end
            rdCnt = 0;
            wrCnt = 0;
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed cases, reset-during-store, back-to-back
   // loads, random traffic, then a final memory image comparison.
   initial begin
      for (int i = 0; i < 16; i++) begin
         memWords[i] = $urandom;
         for (int b = 0; b < 4; b++) refBytes[4 * i + b] = 8'(memWords[i] >> (8 * b));
      end
      memWords[4] = 32'h8899AABB;
      refBytes[16] = 8'hBB; refBytes[17] = 8'hAA; refBytes[18] = 8'h99; refBytes[19] = 8'h88;
      memWords[8] = 32'h11223344;
      refBytes[32] = 8'h44; refBytes[33] = 8'h33; refBytes[34] = 8'h22; refBytes[35] = 8'h11;

      #12;
      checkOutput("rst_memread", {31'h0, MemRead}, 32'h0);
      checkOutput("rst_memwrite", {31'h0, MemWrite}, 32'h0);
      checkOutput("rst_addr", addr, 32'h0);
      checkOutput("rst_wd", WD, 32'h0);
      checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);

      applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, accTmp);
      applyStimulus(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, accTmp);
      applyStimulus(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, accTmp);
      applyStimulus(1'b0, 3'd1, 32'h12, 32'h0, 1'b0, accTmp);
      applyStimulus(1'b0, 3'd5, 32'h10, 32'h0, 1'b0, accTmp);
      applyStimulus(1'b1, 3'd0, 32'h11, 32'h123456CC, 1'b0, accTmp);
      applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, accTmp);
      applyStimulus(1'b1, 3'd1, 32'h12, 32'h0000BEEF, 1'b0, accTmp);
      applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, accTmp);
      applyStimulus(1'b0, 3'd2, 32'h12, 32'h0, 1'b0, accTmp);
      applyStimulus(1'b1, 3'd1, 32'h13, 32'h5555AAAA, 1'b0, accTmp);
      applyStimulus(1'b0, 3'd3, 32'h10, 32'h0, 1'b0, accTmp);
      drain();
      checkOutput("mem_word_0x10", memWords[4], 32'hBEEFCCBB);

      // Reset in the STORE cycle of a SW must cancel the write
      for (int i = 0; i < 4; i++) saved[i] = refBytes[32 + i];
      applyStimulus(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 1'b0, accTmp);
      checkOutput("store_cycle_memwrite", {31'h0, MemWrite}, 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("rst_drops_memwrite", {31'h0, MemWrite}, 32'h0);
      sbq.delete();
      rdCnt = 0;
      wrCnt = 0;
      for (int i = 0; i < 4; i++) refBytes[32 + i] = saved[i];
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mem_word_0x20_kept", memWords[8], 32'h11223344);
      checkOutput("ready_after_rst", {31'h0, req_ready}, 32'h1);
      checkOutput("resp_rdata_after_rst", resp_rdata, 32'h0);

      // Back-to-back loads with req_valid held high
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 3'd2, 32'h10 + 32'(4 * i), 32'h0, 1'b1, accs[i]);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++)
         checkOutput("b2b_spacing", 32'(accs[i + 1] - accs[i]), 32'd3);
      drain();

      for (int k = 0; k < 60; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       32'($urandom_range(0, 63)), $urandom, 1'b0, accTmp);
      end
      drain();

      for (int i = 0; i < 16; i++) checkOutput("final_mem", memWords[i], refWord(4 * i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
